// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the CPU SRAM-like port
// and the bus SRAM-like port; one outstanding request at a time.
module inst_cache #(
  parameter int unsigned INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);

  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned TAG_W = 30 - INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, WAIT, RESP} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               req_wr;
  logic [1:0]         req_size;

  logic [INDEX_W-1:0] req_idx_c;
  logic [TAG_W-1:0]   req_tag_c;
  logic               uncached_c;
  logic               tag_match_c;
  logic               hit_c;
  logic               fill_c;

  assign req_idx_c   = req_addr[INDEX_W+1:2];
  assign req_tag_c   = req_addr[31:INDEX_W+2];
  assign uncached_c  = req_wr | (req_addr[31:29] == 3'b101);
  assign tag_match_c = valid[req_idx_c] & (tag_mem[req_idx_c] == req_tag_c);
  assign hit_c       = ~uncached_c & tag_match_c;
  assign fill_c      = (state == WAIT) & cache_inst_data_ok & ~uncached_c;

  // Line storage; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      data_mem[req_idx_c] <= cache_inst_rdata;
      tag_mem[req_idx_c]  <= req_tag_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      valid            <= '0;
      req_addr         <= '0;
      req_wdata        <= '0;
      req_wr           <= 1'b0;
      req_size         <= 2'b10;
      cpu_inst_rdata   <= '0;
      cpu_inst_addr_ok <= 1'b0;
      cpu_inst_data_ok <= 1'b0;
      cache_inst_req   <= 1'b0;
      cache_inst_wr    <= 1'b0;
      cache_inst_size  <= 2'b10;
      cache_inst_addr  <= '0;
      cache_inst_wdata <= '0;
    end else begin
      cpu_inst_data_ok <= 1'b0;
      cpu_inst_rdata   <= '0;
      case (state)
        IDLE: begin
          if (cpu_inst_req && cpu_inst_addr_ok) begin
            req_addr         <= cpu_inst_addr;
            req_wdata        <= cpu_inst_wdata;
            req_wr           <= cpu_inst_wr;
            req_size         <= cpu_inst_size;
            cpu_inst_addr_ok <= 1'b0;
            state            <= LOOKUP;
          end else begin
            cpu_inst_addr_ok <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit_c) begin
            cpu_inst_data_ok <= 1'b1;
            cpu_inst_rdata   <= data_mem[req_idx_c];
            cpu_inst_addr_ok <= 1'b1;
            state            <= IDLE;
          end else begin
            // A CPU write may be modifying code held in the cache: drop that line.
            if (req_wr && tag_match_c) begin
              valid[req_idx_c] <= 1'b0;
            end
            cache_inst_req <= 1'b1;
            if (uncached_c) begin
              cache_inst_addr  <= req_addr;
              cache_inst_size  <= req_size;
              cache_inst_wr    <= req_wr;
              cache_inst_wdata <= req_wdata;
            end else begin
              cache_inst_addr  <= {req_addr[31:2], 2'b00};
              cache_inst_size  <= 2'b10;
              cache_inst_wr    <= 1'b0;
              cache_inst_wdata <= '0;
            end
            state <= MISS;
          end
        end
        MISS: begin
          if (cache_inst_addr_ok) begin
            cache_inst_req <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (cache_inst_data_ok) begin
            cpu_inst_data_ok <= 1'b1;
            cpu_inst_rdata   <= cache_inst_rdata;
            if (!uncached_c) begin
              valid[req_idx_c] <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          cpu_inst_addr_ok <= 1'b1;
          state            <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed plus randomized checks of inst_cache against a line-address reference model.
module tb_inst_cache;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned LINES   = 2 ** INDEX_W;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_inst_req = 1'b0;
  logic        cpu_inst_wr = 1'b0;
  logic [1:0]  cpu_inst_size = 2'b10;
  logic [31:0] cpu_inst_addr = '0;
  logic [31:0] cpu_inst_wdata = '0;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata = '0;
  logic        cache_inst_addr_ok = 1'b0;
  logic        cache_inst_data_ok = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference: which word address (addr[31:2]) each line index currently holds.
  logic [29:0] line_of   [int];
  logic [31:0] line_data [int];

  inst_cache #(.INDEX_W(INDEX_W)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .cpu_inst_req      (cpu_inst_req),
    .cpu_inst_wr       (cpu_inst_wr),
    .cpu_inst_size     (cpu_inst_size),
    .cpu_inst_addr     (cpu_inst_addr),
    .cpu_inst_wdata    (cpu_inst_wdata),
    .cpu_inst_rdata    (cpu_inst_rdata),
    .cpu_inst_addr_ok  (cpu_inst_addr_ok),
    .cpu_inst_data_ok  (cpu_inst_data_ok),
    .cache_inst_req    (cache_inst_req),
    .cache_inst_wr     (cache_inst_wr),
    .cache_inst_size   (cache_inst_size),
    .cache_inst_addr   (cache_inst_addr),
    .cache_inst_wdata  (cache_inst_wdata),
    .cache_inst_rdata  (cache_inst_rdata),
    .cache_inst_addr_ok(cache_inst_addr_ok),
    .cache_inst_data_ok(cache_inst_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cache_req"},   32'(cache_inst_req), 32'd0);
    chk({tag, "_data_ok"},     32'(cpu_inst_data_ok), 32'd0);
    chk({tag, "_addr_ok"},     32'(cpu_inst_addr_ok), 32'd0);
    chk({tag, "_rdata"},       cpu_inst_rdata, 32'd0);
    chk({tag, "_cache_addr"},  cache_inst_addr, 32'd0);
    chk({tag, "_cache_wdata"}, cache_inst_wdata, 32'd0);
    chk({tag, "_cache_size"},  32'(cache_inst_size), 32'd2);
    chk({tag, "_cache_wr"},    32'(cache_inst_wr), 32'd0);
  endtask

  // One CPU transaction, with the bus side played inline. Called just after a clock edge.
  task automatic access(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic [31:0] wdata, input int ack_dly, input int lat,
                        input logic [31:0] bus_data, input bit stray, input bit abort_in_wait);
    bit          uncached;
    bit          exp_hit;
    int          idx;
    logic [31:0] exp_baddr;
    logic [1:0]  exp_bsize;
    logic        exp_bwr;
    uncached = wr || (addr[31:29] == 3'b101);
    idx      = int'((addr >> 2) % LINES);
    exp_hit  = !uncached && line_of.exists(idx) && (line_of[idx] == addr[31:2]);
    exp_baddr = uncached ? addr : (addr & 32'hFFFF_FFFC);
    exp_bsize = uncached ? size : 2'b10;
    exp_bwr   = uncached ? wr : 1'b0;

    chk("idle_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);
    cpu_inst_req   = 1'b1;
    cpu_inst_addr  = addr;
    cpu_inst_wr    = wr;
    cpu_inst_size  = size;
    cpu_inst_wdata = wdata;
    cache_inst_addr_ok = stray;
    cache_inst_data_ok = stray;
    tick();
    cpu_inst_req       = 1'b0;
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    chk("busy_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    chk("lookup_data_ok", 32'(cpu_inst_data_ok), 32'd0);
    chk("lookup_rdata_zero", cpu_inst_rdata, 32'd0);
    chk("lookup_no_req", 32'(cache_inst_req), 32'd0);

    if (exp_hit) begin
      tick();
      chk("hit_data_ok", 32'(cpu_inst_data_ok), 32'd1);
      chk("hit_rdata", cpu_inst_rdata, line_data[idx]);
      chk("hit_no_req", 32'(cache_inst_req), 32'd0);
      return;
    end

    tick();
    chk("miss_req", 32'(cache_inst_req), 32'd1);
    chk("miss_addr", cache_inst_addr, exp_baddr);
    chk("miss_size", 32'(cache_inst_size), 32'(exp_bsize));
    chk("miss_wr", 32'(cache_inst_wr), 32'(exp_bwr));
    if (uncached) chk("miss_wdata", cache_inst_wdata, wdata);
    chk("miss_data_ok", 32'(cpu_inst_data_ok), 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      cache_inst_data_ok = stray;
      tick();
      chk("bp_req_held", 32'(cache_inst_req), 32'd1);
      chk("bp_addr_stable", cache_inst_addr, exp_baddr);
      chk("bp_cpu_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
      chk("bp_data_ok", 32'(cpu_inst_data_ok), 32'd0);
    end
    cache_inst_data_ok = 1'b0;
    cache_inst_addr_ok = 1'b1;
    tick();
    cache_inst_addr_ok = 1'b0;
    chk("wait_req_dropped", 32'(cache_inst_req), 32'd0);

    if (abort_in_wait) begin
      rstn = 1'b0;
      #1;
      check_reset_outputs("rst_in_wait");
      tick();
      rstn = 1'b1;
      cache_inst_data_ok = 1'b1;
      cache_inst_rdata   = bus_data;
      tick();
      cache_inst_data_ok = 1'b0;
      chk("late_data_ok_ignored", 32'(cpu_inst_data_ok), 32'd0);
      chk("post_reset_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);
      for (int i = 0; i < 2; i++) begin
        tick();
        chk("post_reset_quiet", 32'(cpu_inst_data_ok), 32'd0);
      end
      line_of.delete();
      line_data.delete();
      return;
    end

    for (int i = 1; i < lat; i++) begin
      cache_inst_addr_ok = stray;
      tick();
      chk("wait_data_ok", 32'(cpu_inst_data_ok), 32'd0);
      chk("wait_no_req", 32'(cache_inst_req), 32'd0);
    end
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b1;
    cache_inst_rdata   = bus_data;
    tick();
    cache_inst_data_ok = 1'b0;
    cache_inst_rdata   = $urandom;
    chk("resp_data_ok", 32'(cpu_inst_data_ok), 32'd1);
    chk("resp_rdata", cpu_inst_rdata, bus_data);
    tick();
    chk("after_resp_data_ok", 32'(cpu_inst_data_ok), 32'd0);
    chk("after_resp_rdata", cpu_inst_rdata, 32'd0);
    chk("after_resp_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);

    if (!uncached) begin
      line_of[idx]   = addr[31:2];
      line_data[idx] = bus_data;
    end
    if (wr && line_of.exists(idx) && line_of[idx] == addr[31:2]) begin
      line_of.delete(idx);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    logic [1:0]  sz;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();
    chk("first_edge_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);

    // kseg1 reads always go to the bus
    access(32'hBFC0_0000, 1'b0, 2'b10, '0, 0, 3, 32'h3C1C_BFC0, 1'b0, 1'b0);
    access(32'hBFC0_0000, 1'b0, 2'b10, '0, 0, 3, 32'h279C_0010, 1'b0, 1'b0);
    // cold miss then hit
    access(32'h8000_0010, 1'b0, 2'b10, '0, 0, 3, 32'h2408_0001, 1'b0, 1'b0);
    access(32'h8000_0010, 1'b0, 2'b10, '0, 0, 3, 32'h0, 1'b0, 1'b0);
    // conflict on index 4
    access(32'h8000_0110, 1'b0, 2'b10, '0, 1, 2, 32'h1111_2222, 1'b0, 1'b0);
    access(32'h8000_0010, 1'b0, 2'b10, '0, 0, 3, 32'h2408_0001, 1'b0, 1'b0);
    access(32'h8000_0010, 1'b0, 2'b10, '0, 0, 3, 32'h0, 1'b0, 1'b0);
    // write invalidates, then backpressured refill
    access(32'h8000_0010, 1'b1, 2'b10, 32'hDEAD_BEEF, 0, 2, 32'h0, 1'b0, 1'b0);
    access(32'h8000_0010, 1'b0, 2'b10, '0, 4, 3, 32'h2408_0001, 1'b0, 1'b0);
    access(32'h8000_0010, 1'b0, 2'b10, '0, 0, 3, 32'h0, 1'b0, 1'b0);
    // reset while waiting for bus data
    access(32'h8000_0020, 1'b0, 2'b10, '0, 0, 3, 32'h5555_AAAA, 1'b0, 1'b1);
    access(32'h8000_0020, 1'b0, 2'b10, '0, 0, 3, 32'h1234_5678, 1'b0, 1'b0);
    access(32'h8000_0010, 1'b0, 2'b10, '0, 0, 1, 32'h2408_0001, 1'b0, 1'b0);

    // randomized traffic over a small address pool to force hits, conflicts and invalidates
    for (int n = 0; n < 60; n++) begin
      a = (($urandom_range(0, 3) == 0) ? 32'hA000_0000 : 32'h8000_0000)
          | (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 3)) << 2)
          | 32'($urandom_range(0, 3));
      w  = ($urandom_range(0, 5) == 0);
      sz = 2'($urandom_range(0, 2));
      if (!w && a[31:29] != 3'b101) sz = 2'b10;
      access(a, w, sz, $urandom, $urandom_range(0, 3), $urandom_range(1, 4), $urandom,
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
